uart_cmd_rx: RTL

- Host-to-board half of the scope UART link. Oversamples uart_rx and deserialises 8N1 bytes at the same baud as the ADC sample stream.
- Parses fixed 5-byte command frames (sync, opcode, data_hi, data_lo, checksum) and presents one validated command per frame.
- Sits beside the transmit path in the top level. Its commands drive scope control: sample interval, arm/trigger and LED debug.

---
 rtl/uart_cmd_rx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_cmd_rx.sv
// Host-to-board UART receiver: oversampled 8N1 byte deserialiser feeding a
// 5-byte command frame parser (sync, opcode, data_hi, data_lo, xor checksum).
module uart_cmd_rx #(
   parameter int         DELAY_FRAMES   = 234,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 270000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rx,
   output logic [7:0]  rx_byte,
   output logic        rx_byte_valid,
   output logic        cmd_valid,
   output logic [7:0]  cmd_opcode,
   output logic [15:0] cmd_data,
   output logic        err_framing,
   output logic        err_checksum,
   output logic        err_timeout
);
   localparam int BW = $clog2(DELAY_FRAMES);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [BW-1:0] BIT_END  = BW'(DELAY_FRAMES - 1);
   localparam logic [BW-1:0] HALF_END = BW'(DELAY_FRAMES / 2 - 1);
   localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rxState_t;
   typedef enum logic [2:0] {P_SYNC, P_OP, P_HI, P_LO, P_CHK} pState_t;

   logic          rxMeta, rxSync, rxPrev;
   logic          fallEdge;
   rxState_t      rxState;
   logic [BW-1:0] baudCnt;
   logic [2:0]    bitCnt;
   logic [7:0]    shiftReg;
   pState_t       pState;
   logic [7:0]    opReg, hiReg, loReg;
   logic [TW-1:0] tmoCnt;

   // rxPrev is a third stage used only to find the falling edge of the clean line
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {rxMeta, rxSync, rxPrev} <= 3'b111;
      else        {rxMeta, rxSync, rxPrev} <= {uart_rx, rxMeta, rxSync};

   assign fallEdge = rxPrev & ~rxSync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxState       <= IDLE;
         baudCnt       <= '0;
         bitCnt        <= '0;
         shiftReg      <= '0;
         rx_byte       <= '0;
         rx_byte_valid <= 1'b0;
         err_framing   <= 1'b0;
      end else begin
         rx_byte_valid <= 1'b0;
         err_framing   <= 1'b0;
         case (rxState)
            IDLE:
               if (fallEdge) begin
                  rxState <= START;
                  baudCnt <= '0;
                  bitCnt  <= '0;
               end
            START:
               if (baudCnt == HALF_END) begin
                  baudCnt <= '0;
                  rxState <= rxSync ? IDLE : DATA;   // high at mid-start is a glitch
               end else baudCnt <= baudCnt + 1'b1;
            DATA:
               if (baudCnt == BIT_END) begin
                  baudCnt  <= '0;
                  shiftReg <= {rxSync, shiftReg[7:1]};
                  bitCnt   <= bitCnt + 1'b1;
                  if (bitCnt == 3'd7) rxState <= STOP;
               end else baudCnt <= baudCnt + 1'b1;
            STOP:
               if (baudCnt == BIT_END) begin
                  baudCnt <= '0;
                  if (rxSync) begin
                     rx_byte       <= shiftReg;
                     rx_byte_valid <= 1'b1;
                     rxState       <= IDLE;
                  end else begin
                     err_framing <= 1'b1;
                     rxState     <= WAIT_HIGH;
                  end
               end else baudCnt <= baudCnt + 1'b1;
            WAIT_HIGH:
               if (rxSync) rxState <= IDLE;
            default: rxState <= IDLE;
         endcase
      end
   end

   // A received byte always takes priority over a framing error or timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pState       <= P_SYNC;
         opReg        <= '0;
         hiReg        <= '0;
         loReg        <= '0;
         tmoCnt       <= '0;
         cmd_valid    <= 1'b0;
         cmd_opcode   <= '0;
         cmd_data     <= '0;
         err_checksum <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         cmd_valid    <= 1'b0;
         err_checksum <= 1'b0;
         err_timeout  <= 1'b0;

         if (rx_byte_valid || pState == P_SYNC) tmoCnt <= '0;
         else if (tmoCnt != TMO_MAX)            tmoCnt <= tmoCnt + 1'b1;

         if (rx_byte_valid) begin
            case (pState)
               P_SYNC: if (rx_byte == SYNC_BYTE) pState <= P_OP;
               P_OP: begin
                  opReg  <= rx_byte;
                  pState <= P_HI;
               end
               P_HI: begin
                  hiReg  <= rx_byte;
                  pState <= P_LO;
               end
               P_LO: begin
                  loReg  <= rx_byte;
                  pState <= P_CHK;
               end
               P_CHK: begin
                  if (rx_byte == (opReg ^ hiReg ^ loReg)) begin
                     cmd_valid  <= 1'b1;
                     cmd_opcode <= opReg;
                     cmd_data   <= {hiReg, loReg};
                  end else err_checksum <= 1'b1;
                  pState <= P_SYNC;
               end
               default: pState <= P_SYNC;
            endcase
         end else if (pState != P_SYNC) begin
            if (err_framing) pState <= P_SYNC;
            else if (tmoCnt == TMO_END) begin
               err_timeout <= 1'b1;
               pState      <= P_SYNC;
            end
         end
      end
   end

endmodule
